// File: rtl/pito_mvu_cmd_arbiter.sv
// pito_mvu_cmd_arbiter: round-robin share of the MVU config/command bus across
// barrel harts, with per-hart busy tracking and sticky completion irq.
//
// Ports: clk, rst_n (async, active-low)
//   req_valid/req_ready/req_addr/req_data/req_start : per-hart CSR requests
//   cfg_valid/cfg_ready/cfg_id/cfg_addr/cfg_data/cfg_start : shared bus
//   mvu_done (per-MVU done pulse), busy, irq, irq_ack
// Optional (PITO_MVU_ARB_PERF_CNT_EN): stall_cnt (32b per hart), stall_clr.

module pito_mvu_cmd_arbiter #(
  parameter int N_REQ = 8,
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_start,
  output logic                cfg_valid,
  input  logic                cfg_ready,
  output logic [IDW-1:0]      cfg_id,
  output logic [AW-1:0]       cfg_addr,
  output logic [DW-1:0]       cfg_data,
  output logic                cfg_start,
  input  logic [N_REQ-1:0]    mvu_done,
  output logic [N_REQ-1:0]    busy,
  output logic [N_REQ-1:0]    irq,
  input  logic [N_REQ-1:0]    irq_ack
`ifdef PITO_MVU_ARB_PERF_CNT_EN
  ,
  output logic [N_REQ*32-1:0] stall_cnt,
  input  logic                stall_clr
`endif
);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   gnt;
  logic [IDW-1:0]   idx;
  logic             any_elig;
  logic             run;
  logic             hs;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] busy_nxt;
  logic [N_REQ-1:0] irq_nxt;

  // A hart with a job in flight may not issue anything, not even writes.
  assign elig = req_valid & ~busy;
  assign hs   = cfg_valid & cfg_ready;

  // Search starts just after the last winner; k = N_REQ wraps onto it.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    any_elig = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last_grant + IDW'(k);
      if (!any_elig && elig[idx]) begin
        gnt      = idx;
        any_elig = 1'b1;
      end
    end
  end

  // run keeps req_ready low while reset is held and for the release cycle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && run && any_elig)
      req_ready[gnt] = 1'b1;
  end

  // Start handshake beats a same-cycle done; done beats irq_ack.
  always_comb begin
    busy_nxt = busy;
    irq_nxt  = irq;
    for (int i = 0; i < N_REQ; i++) begin
      if (mvu_done[i] && busy[i]) begin
        busy_nxt[i] = 1'b0;
        irq_nxt[i]  = 1'b1;
      end else if (irq_ack[i]) begin
        irq_nxt[i]  = 1'b0;
      end
      if (hs && cfg_start && cfg_id == IDW'(i))
        busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(N_REQ - 1);
      run        <= 1'b0;
      cfg_valid  <= 1'b0;
      cfg_id     <= '0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      cfg_start  <= 1'b0;
      busy       <= '0;
      irq        <= '0;
    end else begin
      run  <= 1'b1;
      busy <= busy_nxt;
      irq  <= irq_nxt;
      unique case (state)
        IDLE: begin
          if (run && any_elig) begin
            cfg_id    <= gnt;
            cfg_addr  <= req_addr[gnt*AW +: AW];
            cfg_data  <= req_data[gnt*DW +: DW];
            cfg_start <= req_start[gnt];
            cfg_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cfg_ready) begin
            last_grant <= cfg_id;
            cfg_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PITO_MVU_ARB_PERF_CNT_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stall
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stall_cnt[i*32 +: 32] <= '0;
      else if (stall_clr)
        stall_cnt[i*32 +: 32] <= '0;
      else if (req_valid[i] && !req_ready[i] &&
               stall_cnt[i*32 +: 32] != 32'hFFFF_FFFF)
        stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pito_mvu_cmd_arbiter.sv
// tb_pito_mvu_cmd_arbiter: directed checks of grant order, handshake,
// busy/irq tracking and (optional) stall counters.

module tb_pito_mvu_cmd_arbiter;
  localparam int N  = 8;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_start;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            cfg_valid, cfg_ready, cfg_start;
  logic [IW-1:0]   cfg_id;
  logic [AW-1:0]   cfg_addr;
  logic [DW-1:0]   cfg_data;
  logic [N-1:0]    mvu_done, busy, irq, irq_ack;
`ifdef PITO_MVU_ARB_PERF_CNT_EN
  logic [N*32-1:0] stall_cnt;
  logic            stall_clr;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pito_mvu_cmd_arbiter #(
    .N_REQ(N), .AW(AW), .DW(DW), .IDW(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .req_start(req_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_id(cfg_id), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_start(cfg_start),
    .mvu_done(mvu_done), .busy(busy), .irq(irq),
    .irq_ack(irq_ack)
`ifdef PITO_MVU_ARB_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .stall_clr(stall_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_start = '0;
    req_addr  = '0;
    req_data  = '0;
    cfg_ready = 1'b1;
    mvu_done  = '0;
    irq_ack   = '0;
`ifdef PITO_MVU_ARB_PERF_CNT_EN
    stall_clr = 1'b0;
`endif
    #12;
    chk("rst_cfg_valid", 64'(cfg_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    step();

    // single write from hart 3
    req_valid = 8'h08;
    req_addr[3*AW +: AW] = 12'h010;
    req_data[3*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    chk("wr_ready", 64'(req_ready), 64'h08);
    step();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    #1;
    chk("wr_ready_drop", 64'(req_ready), 64'h0);
    chk("wr_valid", 64'(cfg_valid), 64'd1);
    chk("wr_id", 64'(cfg_id), 64'd3);
    chk("wr_addr", 64'(cfg_addr), 64'h010);
    chk("wr_data", 64'(cfg_data), 64'hDEAD_BEEF);
    chk("wr_start", 64'(cfg_start), 64'd0);
    step();
    chk("wr_idle", 64'(cfg_valid), 64'd0);
    chk("wr_busy", 64'(busy), 64'd0);

    // reset in the middle of a start command
    cfg_ready = 1'b0;
    req_valid = 8'h08;
    req_start = 8'h08;
    step();
    chk("mid_valid", 64'(cfg_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(cfg_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_irq", 64'(irq), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    step();
    rst_n     = 1'b1;
    req_start = '0;
    req_valid = 8'hFF;
    cfg_ready = 1'b1;
    step();
    chk("mid_rst_busy2", 64'(busy), 64'd0);

    // round robin over all harts, one command per two cycles
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("rr_ready%0d", k), 64'(req_ready),
          64'(8'h01 << (k % 8)));
      step();
      chk($sformatf("rr_valid%0d", k), 64'(cfg_valid), 64'd1);
      chk($sformatf("rr_id%0d", k), 64'(cfg_id), 64'(k % 8));
      chk($sformatf("rr_bubble%0d", k), 64'(req_ready), 64'd0);
      step();
    end
    req_valid = '0;

    // backpressure on a hart-2 start
    cfg_ready = 1'b0;
    req_valid = 8'h04;
    req_start = 8'h04;
    req_addr[2*AW +: AW] = 12'h222;
    req_data[2*DW +: DW] = 32'h2222_0000;
    #1;
    chk("bp_ready", 64'(req_ready), 64'h04);
    step();
    req_valid = '0;
    req_start = '0;
    req_addr  = '1;
    req_data  = '1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), 64'(cfg_valid), 64'd1);
      chk($sformatf("bp_id%0d", k), 64'(cfg_id), 64'd2);
      chk($sformatf("bp_addr%0d", k), 64'(cfg_addr), 64'h222);
      chk($sformatf("bp_data%0d", k), 64'(cfg_data), 64'h2222_0000);
      chk($sformatf("bp_start%0d", k), 64'(cfg_start), 64'd1);
      chk($sformatf("bp_busy%0d", k), 64'(busy), 64'd0);
      step();
    end
    cfg_ready = 1'b1;
    step();
    chk("bp_busy_set", 64'(busy), 64'h04);
    chk("bp_idle", 64'(cfg_valid), 64'd0);
    req_valid = 8'h24;
    #1;
    chk("bp_block", 64'(req_ready), 64'h20);
    step();
    req_valid = '0;
    chk("bp_id5", 64'(cfg_id), 64'd5);
    chk("bp_start5", 64'(cfg_start), 64'd0);
    step();
    chk("bp_busy5", 64'(busy), 64'h04);

    // done / irq
    mvu_done = 8'h04;
    step();
    mvu_done = '0;
    chk("done_busy", 64'(busy), 64'h00);
    chk("done_irq", 64'(irq), 64'h04);
    req_valid = 8'h04;
    req_start = 8'h04;
    #1;
    chk("job2_ready", 64'(req_ready), 64'h04);
    step();
    req_valid = '0;
    req_start = '0;
    step();
    chk("job2_busy", 64'(busy), 64'h04);
    mvu_done = 8'h04;
    irq_ack  = 8'h04;
    step();
    mvu_done = '0;
    chk("ack_done_busy", 64'(busy), 64'h00);
    chk("ack_done_irq", 64'(irq), 64'h04);
    step();
    irq_ack = '0;
    chk("ack_irq", 64'(irq), 64'h00);
    mvu_done = 8'h40;
    step();
    mvu_done = '0;
    chk("spur_irq", 64'(irq), 64'h00);
    chk("spur_busy", 64'(busy), 64'h00);

`ifdef PITO_MVU_ARB_PERF_CNT_EN
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("sc_clr0", 64'(stall_cnt[0 +: 32]), 64'd0);
    chk("sc_clr1", 64'(stall_cnt[32 +: 32]), 64'd0);
    cfg_ready = 1'b0;
    req_valid = 8'h03;
    step();
    step();
    step();
    step();
    req_valid = '0;
    cfg_ready = 1'b1;
    step();
    chk("sc_cnt1", 64'(stall_cnt[32 +: 32]), 64'd4);
    chk("sc_cnt0", 64'(stall_cnt[0 +: 32]), 64'd3);
    req_valid = 8'h03;
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    req_valid = '0;
    chk("sc_prio1", 64'(stall_cnt[32 +: 32]), 64'd0);
    chk("sc_prio0", 64'(stall_cnt[0 +: 32]), 64'd0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
